range_finder_sequencer: RTL and testbench

- Controller that sequences one RangeFinder datapath (WIDTH-bit samples, go/finish framing, range and debug_error result).
- Accepts a valid/ready sample stream and a per-window length on `start`.
- Frames exactly `cfg_len` samples into one RangeFinder session, waits for the result, and returns it as a one-cycle result pulse.
- Sits between the chip-level input pins / sample source and the RangeFinder instance inside my_chip.

---
 rtl/range_finder_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_range_finder_sequencer.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/range_finder_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : range_finder_sequencer
//  Description : Frames cfg_len valid/ready samples into one RangeFinder
//                go/finish session and returns its range/error result as a
//                one-cycle pulse. Optional stall abort: STALL_TIMEOUT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module range_finder_sequencer #(
    parameter int WIDTH   = 10,
    parameter int LEN_W   = 8,
    parameter int RF_LAT  = 1,
    parameter int TIMEOUT = 255
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [LEN_W-1:0] cfg_len,
    output logic             busy,
    input  logic             s_valid,
    input  logic [WIDTH-1:0] s_data,
    output logic             s_ready,
    output logic [WIDTH-1:0] rf_data,
    output logic             rf_go,
    output logic             rf_finish,
    input  logic [WIDTH-1:0] rf_range,
    input  logic             rf_error,
    output logic             res_valid,
    output logic [WIDTH-1:0] res_range,
    output logic             res_error
);

    localparam int LAT_W = (RF_LAT < 1) ? 1 : $clog2(RF_LAT + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REJECT = 2'd1,
        S_STREAM = 2'd2,
        S_WAIT   = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [LAT_W-1:0]   lat_q, lat_d;
    logic [WIDTH-1:0]   rf_data_q, rf_data_d;
    logic [WIDTH-1:0]   res_range_q, res_range_d;
    logic               rf_go_q, rf_go_d;
    logic               rf_finish_q, rf_finish_d;
    logic               res_error_q, res_error_d;
    logic               abort_q, abort_d;
    logic               xfer;
    logic               lat_done;
    logic               stall_hit;

    assign xfer     = (state_q == S_STREAM) && s_valid;
    assign lat_done = (state_q == S_WAIT) && (lat_q == LAT_W'(RF_LAT));

`ifdef STALL_TIMEOUT_EN
    localparam int ST_W = $clog2(TIMEOUT + 1);

    logic [ST_W-1:0] stall_q, stall_d;

    // Bubbles only count once the session has been opened by a first sample.
    always_comb begin
        stall_d = '0;
        if ((state_q == S_STREAM) && !xfer && (cnt_q != '0)) begin
            stall_d = stall_q + 1'b1;
        end
    end

    assign stall_hit = (state_q == S_STREAM) && !xfer && (cnt_q != '0) &&
                       ((stall_q + 1'b1) == ST_W'(TIMEOUT));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^32'(TIMEOUT);
    assign stall_hit      = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        lat_d       = lat_q;
        rf_data_d   = rf_data_q;
        rf_go_d     = 1'b0;
        rf_finish_d = 1'b0;
        res_range_d = res_range_q;
        res_error_d = res_error_q;
        abort_d     = abort_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (cfg_len < LEN_W'(2)) begin
                        state_d = S_REJECT;
                    end else begin
                        len_d   = cfg_len;
                        cnt_d   = '0;
                        abort_d = 1'b0;
                        state_d = S_STREAM;
                    end
                end
            end
            S_REJECT: begin
                res_range_d = '0;
                res_error_d = 1'b1;
                state_d     = S_IDLE;
            end
            S_STREAM: begin
                if (xfer) begin
                    rf_data_d = s_data;
                    cnt_d     = cnt_q + 1'b1;
                    rf_go_d   = (cnt_q == '0);
                    if (cnt_q == len_q - 1'b1) begin
                        rf_finish_d = 1'b1;
                        lat_d       = '0;
                        state_d     = S_WAIT;
                    end
                end else if (stall_hit) begin
                    // Close the session on the held sample; result is flagged.
                    rf_finish_d = 1'b1;
                    lat_d       = '0;
                    abort_d     = 1'b1;
                    state_d     = S_WAIT;
                end
            end
            S_WAIT: begin
                if (lat_done) begin
                    res_range_d = rf_range;
                    res_error_d = rf_error | abort_q;
                    state_d     = S_IDLE;
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            cnt_q       <= '0;
            lat_q       <= '0;
            rf_data_q   <= '0;
            rf_go_q     <= 1'b0;
            rf_finish_q <= 1'b0;
            res_range_q <= '0;
            res_error_q <= 1'b0;
            abort_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            lat_q       <= lat_d;
            rf_data_q   <= rf_data_d;
            rf_go_q     <= rf_go_d;
            rf_finish_q <= rf_finish_d;
            res_range_q <= res_range_d;
            res_error_q <= res_error_d;
            abort_q     <= abort_d;
        end
    end

    // During the pulse the fresh value is presented directly, then held.
    assign busy      = (state_q != S_IDLE);
    assign s_ready   = (state_q == S_STREAM);
    assign rf_data   = rf_data_q;
    assign rf_go     = rf_go_q;
    assign rf_finish = rf_finish_q;
    assign res_valid = (state_q == S_REJECT) || lat_done;
    assign res_range = res_valid ? res_range_d : res_range_q;
    assign res_error = res_valid ? res_error_d : res_error_q;

endmodule
`default_nettype wire

// File: tb/tb_range_finder_sequencer.sv
`default_nettype none
// Self-checking bench for range_finder_sequencer: directed scenarios plus
// randomized traffic compared every cycle against a transaction-level model.
module tb_range_finder_sequencer;

    localparam int WIDTH   = 10;
    localparam int LEN_W   = 8;
    localparam int RF_LAT  = 1;
    localparam int TIMEOUT = 8;

    logic             clock   = 1'b0;
    logic             reset_n = 1'b0;
    logic             start   = 1'b0;
    logic [LEN_W-1:0] cfg_len = '0;
    logic             s_valid = 1'b0;
    logic [WIDTH-1:0] s_data  = '0;
    logic             rf_error = 1'b0;
    logic             busy, s_ready, rf_go, rf_finish, res_valid, res_error;
    logic [WIDTH-1:0] rf_data, res_range, rf_range;

    int n_cmp = 0;
    int n_bad = 0;

    range_finder_sequencer #(
        .WIDTH(WIDTH), .LEN_W(LEN_W), .RF_LAT(RF_LAT), .TIMEOUT(TIMEOUT)
    ) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .cfg_len(cfg_len),
        .busy(busy), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .rf_data(rf_data), .rf_go(rf_go), .rf_finish(rf_finish),
        .rf_range(rf_range), .rf_error(rf_error), .res_valid(res_valid),
        .res_range(res_range), .res_error(res_error)
    );

    always #5 clock = ~clock;

    // Minimal RangeFinder: tracks min/max since go, range valid one cycle later.
    logic [WIDTH-1:0] rf_min_q = '0;
    logic [WIDTH-1:0] rf_max_q = '0;
    always @(posedge clock) begin
        if (rf_go) begin
            rf_min_q <= rf_data;
            rf_max_q <= rf_data;
        end else begin
            if (rf_data < rf_min_q) rf_min_q <= rf_data;
            if (rf_data > rf_max_q) rf_max_q <= rf_data;
        end
    end
    assign rf_range = rf_max_q - rf_min_q;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    int  cyc = 0;
    bit  m_stream = 0;
    int  m_len = 0, m_cnt = 0, m_stall = 0;
    bit  m_to = 0;
    int  m_min = 0, m_max = 0;
    int  busy_until = -1, result_at = -1;
    bit  res_rej = 0;
    bit  e_go = 0, e_fin = 0;
    int  e_data = 0;
    int  h_range = 0;
    bit  h_err = 0;
    int  go_seen = 0, fin_seen = 0, rv_seen = 0;
    bit  m_idle, m_rv;
    int  xr;
    bit  xe;

    always @(negedge clock) begin
        cyc++;
        if (!reset_n) begin
            m_stream = 0; busy_until = -1; result_at = -1; m_to = 0;
            e_go = 0; e_fin = 0; e_data = 0; h_range = 0; h_err = 0;
            check("rst_busy", busy, 0);
            check("rst_s_ready", s_ready, 0);
            check("rst_rf_go", rf_go, 0);
            check("rst_rf_finish", rf_finish, 0);
            check("rst_rf_data", rf_data, 0);
            check("rst_res_valid", res_valid, 0);
            check("rst_res_range", res_range, 0);
            check("rst_res_error", res_error, 0);
        end else begin
            m_idle = !m_stream && (cyc > busy_until);
            m_rv   = (cyc == result_at);
            if (m_rv) begin
                if (res_rej) begin xr = 0; xe = 1; end
                else begin xr = m_max - m_min; xe = rf_error | m_to; end
                h_range = xr;
                h_err   = xe;
            end
            check("busy", busy, !m_idle);
            check("s_ready", s_ready, m_stream);
            check("rf_go", rf_go, e_go);
            check("rf_finish", rf_finish, e_fin);
            check("rf_data", rf_data, e_data);
            check("res_valid", res_valid, m_rv);
            check("res_range", res_range, h_range);
            check("res_error", res_error, h_err);
            check("go_finish_excl", rf_go && rf_finish, 0);
            go_seen  += rf_go;
            fin_seen += rf_finish;
            rv_seen  += res_valid;

            e_go = 0;
            e_fin = 0;
            if (m_stream) begin
                if (s_valid) begin
                    m_cnt++;
                    m_stall = 0;
                    e_data = s_data;
                    if (m_cnt == 1) begin
                        m_min = s_data; m_max = s_data; e_go = 1;
                    end else begin
                        if (s_data < m_min) m_min = s_data;
                        if (s_data > m_max) m_max = s_data;
                    end
                    if (m_cnt == m_len) begin
                        e_fin = 1; m_stream = 0; res_rej = 0;
                        result_at = cyc + 1 + RF_LAT; busy_until = result_at;
                    end
                end
`ifdef STALL_TIMEOUT_EN
                else if (m_cnt > 0) begin
                    m_stall++;
                    if (m_stall == TIMEOUT) begin
                        e_fin = 1; m_stream = 0; res_rej = 0; m_to = 1;
                        result_at = cyc + 1 + RF_LAT; busy_until = result_at;
                    end
                end
`endif
            end else if (m_idle && start) begin
                if (cfg_len < 2) begin
                    res_rej = 1; result_at = cyc + 1; busy_until = cyc + 1;
                end else begin
                    m_stream = 1; m_len = cfg_len; m_cnt = 0; m_stall = 0; m_to = 0;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_start(input int len);
        start = 1'b1;
        cfg_len = LEN_W'(len);
        tick();
        start = 1'b0;
    endtask

    task automatic send(input int d, input int gap);
        bit ok;
        int n;
        s_valid = 1'b0;
        repeat (gap) tick();
        s_valid = 1'b1;
        s_data = WIDTH'(d);
        n = 0;
        ok = 0;
        while (!ok && n < 300) begin
            @(negedge clock);
            ok = s_ready;
            tick();
            n++;
        end
        s_valid = 1'b0;
        if (!ok) check("send_timeout", 0, 1);
    endtask

    task automatic wait_result(output int k, output int rr, output int re);
        k = 0;
        do begin
            @(negedge clock);
            k++;
        end while (!res_valid && k < 1000);
        if (!res_valid) check("result_timeout", 0, 1);
        rr = res_range;
        re = res_error;
    endtask

    int k, rr, re, g0, f0, r0, mn, mx, d;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (2) tick();
        reset_n = 1'b1;
        tick();

        // Back-to-back window of four samples.
        do_start(4);
        g0 = go_seen; f0 = fin_seen;
        send(10, 0);
        check("t2_go_first", rf_go, 1);
        check("t2_data_first", rf_data, 10);
        send(50, 0); send(20, 0); send(30, 0);
        check("t2_fin_last", rf_finish, 1);
        check("t2_data_last", rf_data, 30);
        wait_result(k, rr, re);
        check("t2_latency", k, 1 + RF_LAT);
        check("t2_range", rr, 40);
        check("t2_error", re, 0);
        tick();

        // Bubbles between samples.
        do_start(3);
        g0 = go_seen; f0 = fin_seen;
        send(100, 0); send(7, 4); send(60, 4);
        wait_result(k, rr, re);
        check("t3_range", rr, 93);
        tick();
        check("t3_go_count", go_seen - g0, 1);
        check("t3_fin_count", fin_seen - f0, 1);

        // Rejected lengths.
        for (int l = 0; l < 2; l++) begin
            g0 = go_seen;
            do_start(l);
            wait_result(k, rr, re);
            check("t4_latency", k, 1);
            check("t4_range", rr, 0);
            check("t4_error", re, 1);
            tick();
            check("t4_no_go", go_seen - g0, 0);
        end

        // start held high for a whole window; cfg_len changed mid-window.
        rf_error = 1'b1;
        start = 1'b1;
        cfg_len = 8'd2;
        tick();
        cfg_len = 8'd9;
        g0 = go_seen;
        send(3, 0);
        send(11, 0);
        cfg_len = 8'd2;
        wait_result(k, rr, re);
        check("t5_range", rr, 8);
        check("t5_error", re, 1);
        @(negedge clock);
        check("t5_idle_after", busy, 0);
        @(negedge clock);
        check("t5_restart", busy, 1);
        tick();
        start = 1'b0;
        rf_error = 1'b0;
        check("t5_one_window", go_seen - g0, 1);
        send(1, 0); send(2, 0);
        wait_result(k, rr, re);
        check("t5b_range", rr, 1);
        tick();

        // Reset in the middle of a window.
        do_start(5);
        send(40, 0); send(90, 0); send(70, 0);
        r0 = rv_seen;
        reset_n = 1'b0;
        #1;
        check("t1_busy", busy, 0);
        check("t1_s_ready", s_ready, 0);
        check("t1_rf_data", rf_data, 0);
        check("t1_res_range", res_range, 0);
        tick(); tick();
        reset_n = 1'b1;
        repeat (5) tick();
        check("t1_no_result", rv_seen - r0, 0);
        do_start(2);
        send(3, 0); send(8, 0);
        wait_result(k, rr, re);
        check("t1_next_range", rr, 5);
        tick();

        // Maximum window length.
        do_start(255);
        mn = 1 << WIDTH; mx = -1;
        for (int i = 0; i < 255; i++) begin
            d = int'($urandom_range(0, (1 << WIDTH) - 1));
            if (d < mn) mn = d;
            if (d > mx) mx = d;
            send(d, 0);
        end
        wait_result(k, rr, re);
        check("t6_range", rr, mx - mn);
        check("t6_error", re, 0);
        tick();

`ifdef STALL_TIMEOUT_EN
        // Stall abort after two samples.
        do_start(5);
        send(5, 0); send(9, 0);
        k = 0;
        do begin
            @(negedge clock);
            k++;
        end while (!rf_finish && k < 100);
        check("t7_finish_delay", k, TIMEOUT + 1);
        check("t7_data_held", rf_data, 9);
        wait_result(k, rr, re);
        check("t7_range", rr, 4);
        check("t7_error", re, 1);
        tick();
`endif

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            start    = ($urandom_range(0, 5) == 0);
            cfg_len  = LEN_W'($urandom_range(0, 9));
            s_valid  = ($urandom_range(0, 2) != 0);
            s_data   = WIDTH'($urandom);
            rf_error = $urandom_range(0, 1) == 1;
            tick();
        end
        start = 1'b0;
        s_valid = 1'b1;
        k = 0;
        while (busy && k < 300) begin
            tick();
            k++;
        end
        s_valid = 1'b0;
        check("drain_idle", busy, 0);
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
